// File: rtl/params_noc.sv
// Package params_noc: router-wide NoC parameters and shared types.
//   in_Port_Cnt   : number of router ports (LOCAL plus four mesh directions)
//   inout_Port    : port identifier enum used for routing decisions
//   BUF_DEPTH_DEF : default flit slots per downstream VC buffer
//   CRED_W        : credit counter width able to hold 0..BUF_DEPTH_DEF
//   OWN_W         : width of an input-port index stored as VC owner
package params_noc;

  localparam int in_Port_Cnt = 5;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    EAST  = 3'd4
  } inout_Port;

  localparam int BUF_DEPTH_DEF = 8;
  localparam int CRED_W        = $clog2(BUF_DEPTH_DEF + 1);
  localparam int OWN_W         = $clog2(in_Port_Cnt);

endpackage

// File: rtl/credit_counter.sv
// credit_counter: credit count for one downstream output VC buffer.
// Ports:
//   clk       : router clock
//   rst       : synchronous active-high reset, reloads the full credit count
//   dec       : one flit sent downstream (consumes a credit)
//   inc       : one credit returned by the downstream router
//   count     : current credit count (registered)
//   nonzero   : count != 0 (registered alongside count)
//   ovf_pulse : a return arrived while already full (combinational, this cycle)
module credit_counter
  import params_noc::*;
#(
  parameter int DEPTH = BUF_DEPTH_DEF,
  parameter int W     = CRED_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         dec,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         nonzero,
  output logic         ovf_pulse
);

  localparam logic [W-1:0] FULL = W'(DEPTH);
  localparam logic [W-1:0] ZERO = {W{1'b0}};
  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_r;
  logic [W-1:0] count_nxt_s;
  logic         nonzero_r;
  logic         ovf_s;

  // Next-count selection; a full counter saturates and flags the extra return
  always_comb begin
    count_nxt_s = count_r;
    ovf_s       = 1'b0;
    case ({inc, dec})
      2'b10: begin
        if (count_r == FULL) begin
          ovf_s       = 1'b1;
          count_nxt_s = count_r;
        end else begin
          count_nxt_s = count_r + ONE;
        end
      end
      2'b01: begin
        // The request mask keeps dec away from an empty counter; hold as a guard
        if (count_r != ZERO) begin
          count_nxt_s = count_r - ONE;
        end else begin
          count_nxt_s = count_r;
        end
      end
      default: count_nxt_s = count_r;
    endcase
  end

  // Count and nonzero flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r   <= FULL;
      nonzero_r <= 1'b1;
    end else begin
      count_r   <= count_nxt_s;
      nonzero_r <= (count_nxt_s != ZERO);
    end
  end

  assign count     = count_r;
  assign nonzero   = nonzero_r;
  assign ovf_pulse = ovf_s;

endmodule

// File: rtl/sa_credit_ctrl.sv
// sa_credit_ctrl: credit and output-VC ownership controller ahead of the
// switch allocator. Output VC index equals input VC index.
// Ports:
//   clk, rst_n     : router clock; synchronous active-high reset
//   flit_valid_i   : head-of-queue flit present per input VC
//   flit_head_i    : that flit is a head flit
//   flit_tail_i    : that flit is a tail flit (head+tail = single-flit packet)
//   flit_dest_i    : routed output port of that flit
//   request_o      : masked request to the allocator (combinational)
//   out_port_o     : pass-through of flit_dest_i to the allocator
//   grant_i        : allocator grant, same cycle as request_o
//   credit_i       : credit return per output port / VC
//   credit_avail_o : output VC credit count is nonzero
//   ovf_err_o      : sticky credit-overflow error
module sa_credit_ctrl
  import params_noc::*;
#(
  parameter int vc_Num    = 4,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [in_Port_Cnt-1:0][vc_Num-1:0]  flit_valid_i,
  input  logic [in_Port_Cnt-1:0][vc_Num-1:0]  flit_head_i,
  input  logic [in_Port_Cnt-1:0][vc_Num-1:0]  flit_tail_i,
  input  inout_Port                           flit_dest_i [in_Port_Cnt][vc_Num],
  output logic [in_Port_Cnt-1:0][vc_Num-1:0]  request_o,
  output inout_Port                           out_port_o [in_Port_Cnt][vc_Num],
  input  logic [in_Port_Cnt-1:0][vc_Num-1:0]  grant_i,
  input  logic [in_Port_Cnt-1:0][vc_Num-1:0]  credit_i,
  output logic [in_Port_Cnt-1:0][vc_Num-1:0]  credit_avail_o,
  output logic                                ovf_err_o
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [in_Port_Cnt-1:0][vc_Num-1:0] request_s;
  logic [in_Port_Cnt-1:0][vc_Num-1:0] eff_grant_s;
  logic [in_Port_Cnt-1:0][vc_Num-1:0] dec_s;
  logic [in_Port_Cnt-1:0][vc_Num-1:0] lock_s;
  logic [in_Port_Cnt-1:0][vc_Num-1:0] unlock_s;
  logic [in_Port_Cnt-1:0][vc_Num-1:0] nonzero_s;
  logic [in_Port_Cnt-1:0][vc_Num-1:0] ovf_pulse_s;
  logic [OWN_W-1:0]                   lock_ip_s [in_Port_Cnt][vc_Num];
  logic [CNT_W-1:0]                   cnt_s     [in_Port_Cnt][vc_Num];

  logic [in_Port_Cnt-1:0][vc_Num-1:0] own_vld_r;
  logic [OWN_W-1:0]                   own_ip_r  [in_Port_Cnt][vc_Num];
  logic                               ovf_err_r;

  // Request masking: downstream credit present and output VC ownership compatible
  always_comb begin
    request_s = '0;
    for (int i = 0; i < in_Port_Cnt; i++) begin
      for (int v = 0; v < vc_Num; v++) begin
        // Destinations outside the port range are never requested
        if (!rst_n && flit_valid_i[i][v] && (int'(flit_dest_i[i][v]) < in_Port_Cnt)) begin
          if (cnt_s[flit_dest_i[i][v]][v] == {CNT_W{1'b0}}) begin
            request_s[i][v] = 1'b0;
          end else if (flit_head_i[i][v]) begin
            request_s[i][v] = !own_vld_r[flit_dest_i[i][v]][v];
          end else begin
            // Body/tail only continues a packet this input already owns
            request_s[i][v] = own_vld_r[flit_dest_i[i][v]][v] &&
                              (own_ip_r[flit_dest_i[i][v]][v] == OWN_W'(i));
          end
        end else begin
          request_s[i][v] = 1'b0;
        end
      end
    end
  end

  // Grant decode per output VC; descending scan leaves the lowest input as winner
  always_comb begin
    eff_grant_s = grant_i & request_s;
    dec_s       = '0;
    lock_s      = '0;
    unlock_s    = '0;
    for (int p = 0; p < in_Port_Cnt; p++) begin
      for (int v = 0; v < vc_Num; v++) begin
        lock_ip_s[p][v] = {OWN_W{1'b0}};
      end
    end
    for (int p = 0; p < in_Port_Cnt; p++) begin
      for (int v = 0; v < vc_Num; v++) begin
        for (int i = in_Port_Cnt - 1; i >= 0; i--) begin
          if (eff_grant_s[i][v] && (3'(flit_dest_i[i][v]) == 3'(p))) begin
            dec_s[p][v]     = 1'b1;
            lock_s[p][v]    = flit_head_i[i][v] && !flit_tail_i[i][v];
            unlock_s[p][v]  = flit_tail_i[i][v] && !flit_head_i[i][v];
            lock_ip_s[p][v] = OWN_W'(i);
          end else begin
            dec_s[p][v] = dec_s[p][v];
          end
        end
      end
    end
  end

  for (genvar gp = 0; gp < in_Port_Cnt; gp++) begin : g_port
    for (genvar gv = 0; gv < vc_Num; gv++) begin : g_vc
      credit_counter #(
        .DEPTH (BUF_DEPTH),
        .W     (CNT_W)
      ) u_cnt (
        .clk       (clk),
        .rst       (rst_n),
        .dec       (dec_s[gp][gv]),
        .inc       (credit_i[gp][gv]),
        .count     (cnt_s[gp][gv]),
        .nonzero   (nonzero_s[gp][gv]),
        .ovf_pulse (ovf_pulse_s[gp][gv])
      );
    end
  end

  // Output VC ownership and sticky overflow registers
  always_ff @(posedge clk) begin
    if (rst_n) begin
      own_vld_r <= '0;
      for (int p = 0; p < in_Port_Cnt; p++) begin
        for (int v = 0; v < vc_Num; v++) begin
          own_ip_r[p][v] <= {OWN_W{1'b0}};
        end
      end
      ovf_err_r <= 1'b0;
    end else begin
      for (int p = 0; p < in_Port_Cnt; p++) begin
        for (int v = 0; v < vc_Num; v++) begin
          if (lock_s[p][v]) begin
            own_vld_r[p][v] <= 1'b1;
            own_ip_r[p][v]  <= lock_ip_s[p][v];
          end else if (unlock_s[p][v]) begin
            own_vld_r[p][v] <= 1'b0;
          end else begin
            own_vld_r[p][v] <= own_vld_r[p][v];
          end
        end
      end
      ovf_err_r <= ovf_err_r | (|ovf_pulse_s);
    end
  end

  // Routed port passes straight through to the allocator
  always_comb begin
    for (int i = 0; i < in_Port_Cnt; i++) begin
      for (int v = 0; v < vc_Num; v++) begin
        out_port_o[i][v] = flit_dest_i[i][v];
      end
    end
  end

  assign request_o      = request_s;
  assign credit_avail_o = nonzero_s;
  assign ovf_err_o      = ovf_err_r;

endmodule

// File: doc/sa_credit_ctrl.md
# sa_credit_ctrl

Credit and output-VC ownership controller in front of `in_out_allocator` in each router. Per input VC, it decides each cycle whether the waiting flit may bid for switch allocation. A flit is eligible when its downstream buffer has credit and its output VC is free or already owned by that input's packet. It consumes allocator grants to decrement credits and lock or release output VCs, and takes credit returns from downstream routers.

## Interface
- `vc_Num`, 4, virtual channels per port; output VC index equals input VC index (static VC mapping).
- `BUF_DEPTH`, 8, flit slots per downstream VC buffer; initial and maximum credit count.
- `clk`  in  1  router clock.
- `rst_n`  in  1  reset, synchronous, active-high (asserted = 1).
- `flit_valid_i`  in  `[in_Port_Cnt][vc_Num]`  head-of-queue flit present in input VC buffer.
- `flit_head_i`  in  `[in_Port_Cnt][vc_Num]`  that flit is a head flit.
- `flit_tail_i`  in  `[in_Port_Cnt][vc_Num]`  that flit is a tail flit; head and tail may both be 1 (single-flit packet).
- `flit_dest_i`  in  `inout_Port [vc_Num]` × `[in_Port_Cnt]`  routed output port of that flit.
- `request_o`  out  `[in_Port_Cnt][vc_Num]`  masked request; drives allocator `request_in`.
- `out_port_o`  out  `inout_Port [vc_Num]` × `[in_Port_Cnt]`  pass-through of `flit_dest_i`; drives allocator `inports_Out`.
- `grant_i`  in  `[in_Port_Cnt][vc_Num]`  allocator `grant_o`, same cycle as `request_o`.
- `credit_i`  in  `[in_Port_Cnt][vc_Num]`  one credit returned for output port p, VC v.
- `credit_avail_o`  out  `[in_Port_Cnt][vc_Num]`  credit count of output VC (p,v) is nonzero.
- `ovf_err_o`  out  1  sticky credit-overflow error.

## Operation
- State per output VC (p,v):
  - `cnt[p][v]`, width `$clog2(BUF_DEPTH+1)`.
  - `own_vld[p][v]`.
  - `own_ip[p][v]`, width `$clog2(in_Port_Cnt)`.
- Eligibility of input VC (i,v), with d = `flit_dest_i[i][v]`:
  - Requires `flit_valid_i` and `cnt[d][v] != 0`.
  - Head flit: additionally requires `own_vld[d][v] == 0`.
  - Body or tail flit: additionally requires `own_vld[d][v] == 1` and `own_ip[d][v] == i`.
  - A body or tail flit with no matching owner is never requested. It is not an error.
- `request_o[i][v]` is the eligibility above. It is combinational from inputs and current state.
- Effective grant = `grant_i & request_o`. Grant bits without a request are ignored and change no state.
- On an effective grant to (i,v) with destination d:
  - `cnt[d][v]` decrements by 1.
  - Head without tail: set `own_vld[d][v]=1`, `own_ip[d][v]=i`.
  - Tail: clear `own_vld[d][v]`.
  - Head and tail together: ownership unchanged (stays free).
- Credit update per (p,v), using effective grant g and `credit_i` c:
  - g and c together: count unchanged.
  - c only: +1.
  - g only: −1.
- Overflow: c only while `cnt == BUF_DEPTH` → count holds at `BUF_DEPTH` and `ovf_err_o` sets. `ovf_err_o` clears only on reset.
- Underflow cannot occur, because a zero count masks the request.
- Two heads in the same cycle targeting the same free output VC (p,v) from different inputs:
  - Both are requested.
  - The allocator grants at most one input per output port, so at most one lock per (p,v) per cycle.
  - If `grant_i` nevertheless shows more than one effective grant to the same (p,v), the lowest input index takes ownership and the count decrements by 1.

## Timing
- Request path is zero latency: `request_o` and `out_port_o` are valid in the same cycle as the flit inputs.
- Grant effects (count and ownership) are visible at the next `posedge clk`, so `request_o` reflects them one cycle after the grant.
- Returned credit is usable one cycle after `credit_i`.
- Reset (`rst_n=1` sampled at posedge):
  - All `cnt = BUF_DEPTH`, all `own_vld = 0`, `ovf_err_o = 0`.
  - `request_o` is forced to 0 while `rst_n = 1`.
  - `credit_avail_o` reads all-ones after the first reset edge.
- Reset mid-packet drops all locks and restores full credit. Upstream and downstream routers are reset by the same `rst_n`.

## Structure
- Package `params_noc`:
  - Existing: `in_Port_Cnt`, `inout_Port` enum {LOCAL, NORTH, SOUTH, WEST, EAST}.
  - Add: `BUF_DEPTH` default, credit width localparam `CRED_W`.
- Sub-module `credit_counter`: one per output VC, so `in_Port_Cnt*vc_Num` instances.
  - Inputs: dec, inc, rst.
  - Outputs: count, nonzero, overflow pulse.
- Ownership registers and request masking live in the top module.

## Test plan
- Reset, then check outputs: `rst_n=1` for 2 cycles, then 0 → `credit_avail_o` all 1, `request_o` 0 during reset, `ovf_err_o=0`.
- Credit exhaustion: single-flit packets from input LOCAL VC0 to EAST, granted every cycle, no `credit_i`.
  - 8 grants are accepted.
  - On the 9th cycle `request_o[LOCAL][0]=0` and `credit_avail_o[EAST][0]=0`.
  - One `credit_i[EAST][0]` re-enables the request the next cycle.
- Ownership: NORTH VC1 sends a head toward WEST and is granted.
  - SOUTH VC1 head toward WEST → `request_o[SOUTH][1]=0` until the NORTH tail is granted, then 1 the following cycle.
- Orphan body: body flit at WEST VC2 with no owner → `request_o[WEST][2]=0` indefinitely, no count change.
- Simultaneous grant and credit on EAST VC3 at count 5 → count stays 5. Credit return at count 8 → stays 8 and `ovf_err_o=1` until reset.
- Random cross-check, 1000 cycles: connect the real `in_out_allocator`, with random flits and credits. The reference model checks:
  - credits never negative;
  - at most one owner per output VC;
  - sum of outstanding credits is conserved.
